// File: rtl/pipelined_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pipelined_shifter                                               |
// | Brief    : Pipelined barrel shifter (SLL/SRL/SRA/ROR) with carry/zero      |
// |            flags and a valid/ready handshake using a global stall.         |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module pipelined_shifter #(
   parameter int  WIDTH       = 16,
   parameter int  PIPE_STAGES = 2,
   localparam int AW          = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [AW-1:0]    in_amount,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_carry,
   output logic             out_zero
);

   localparam int         LPS      = (AW + PIPE_STAGES - 1) / PIPE_STAGES;
   localparam logic [1:0] MODE_SLL = 2'b00;
   localparam logic [1:0] MODE_SRL = 2'b01;
   localparam logic [1:0] MODE_SRA = 2'b10;

   // Link index s is the input of stage s; index PIPE_STAGES is the output.
   logic             lnk_valid [PIPE_STAGES+1];
   logic [WIDTH-1:0] lnk_data  [PIPE_STAGES+1];
   logic             lnk_carry [PIPE_STAGES+1];
   logic [1:0]       lnk_mode  [PIPE_STAGES];
   logic [AW-1:0]    lnk_amt   [PIPE_STAGES];
   logic             advance;

   assign advance      = !lnk_valid[PIPE_STAGES] || out_ready;
   assign in_ready     = advance;

   assign lnk_valid[0] = in_valid;
   assign lnk_data[0]  = in_data;
   assign lnk_carry[0] = 1'b0;
   assign lnk_mode[0]  = in_mode;
   assign lnk_amt[0]   = in_amount;

   genvar s;
   generate
      for (s = 0; s < PIPE_STAGES; s++) begin : g_stage
         localparam int LO   = (s * LPS < AW) ? s * LPS : AW;
         localparam int HI   = ((s + 1) * LPS < AW) ? (s + 1) * LPS : AW;
         localparam bit LAST = (s == PIPE_STAGES - 1);

         logic             valid_q, valid_d;
         logic [WIDTH-1:0] data_q, data_d;
         logic             carry_q, carry_d;

         // Carry is taken at every active level; the highest active level
         // shifts last, so its outgoing bit is the overall last bit out.
         always_comb begin
            valid_d = lnk_valid[s];
            data_d  = lnk_data[s];
            carry_d = lnk_carry[s];
            for (int k = LO; k < HI; k++) begin
               if (lnk_amt[s][k]) begin
                  if (lnk_mode[s] == MODE_SLL) begin
                     carry_d = data_d[WIDTH - (1 << k)];
                     data_d  = data_d << (1 << k);
                  end else begin
                     carry_d = data_d[(1 << k) - 1];
                     case (lnk_mode[s])
                        MODE_SRL: data_d = data_d >> (1 << k);
                        MODE_SRA: data_d = $unsigned($signed(data_d) >>> (1 << k));
                        default:  data_d = (data_d >> (1 << k)) | (data_d << (WIDTH - (1 << k)));
                     endcase
                  end
               end
            end
            if (LAST) begin
               carry_d = carry_d & (|lnk_amt[s]);
            end
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               valid_q <= 1'b0;
               data_q  <= '0;
               carry_q <= 1'b0;
            end else if (advance) begin
               valid_q <= valid_d;
               data_q  <= data_d;
               carry_q <= carry_d;
            end
         end

         assign lnk_valid[s+1] = valid_q;
         assign lnk_data[s+1]  = data_q;
         assign lnk_carry[s+1] = carry_q;

         if (LAST) begin : g_last
            logic zero_q, zero_d;

            always_comb begin
               zero_d = (data_d == '0);
            end

            always_ff @(posedge clk or posedge reset) begin
               if (reset) begin
                  zero_q <= 1'b0;
               end else if (advance) begin
                  zero_q <= zero_d;
               end
            end

            assign out_zero = zero_q;
         end else begin : g_fwd
            logic [1:0]    mode_q, mode_d;
            logic [AW-1:0] amt_q, amt_d;

            always_comb begin
               mode_d = lnk_mode[s];
               amt_d  = lnk_amt[s];
            end

            always_ff @(posedge clk or posedge reset) begin
               if (reset) begin
                  mode_q <= 2'b00;
                  amt_q  <= '0;
               end else if (advance) begin
                  mode_q <= mode_d;
                  amt_q  <= amt_d;
               end
            end

            assign lnk_mode[s+1] = mode_q;
            assign lnk_amt[s+1]  = amt_q;
         end
      end
   endgenerate

   assign out_valid = lnk_valid[PIPE_STAGES];
   assign out_data  = lnk_data[PIPE_STAGES];
   assign out_carry = lnk_carry[PIPE_STAGES];

endmodule
`default_nettype wire

// File: tb/tb_pipelined_shifter.sv
`default_nettype none
// Scoreboard bench for pipelined_shifter: directed spec cases, stall, mid-flight
// reset and randomized traffic compared against an arithmetic reference model.
module tb_pipelined_shifter;

   localparam int W  = 16;
   localparam int P  = 2;
   localparam int AW = $clog2(W);

   typedef struct packed {
      logic [W-1:0] d;
      logic         c;
      logic         z;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic [AW-1:0] in_amount;
   logic [1:0]    in_mode;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;
   logic          out_carry;
   logic          out_zero;

   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];
   bit   rnd_done;

   pipelined_shifter #(.WIDTH(W), .PIPE_STAGES(P)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_amount(in_amount), .in_mode(in_mode),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_carry(out_carry), .out_zero(out_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, want, $time);
      end
   endtask

   // Reference: shift a widened operand so the bit pushed out lands in a guard position.
   function automatic exp_t model(input logic [W-1:0] d, input logic [AW-1:0] a, input logic [1:0] m);
      logic [W:0]     wide;
      logic [2*W-1:0] dbl;
      exp_t           e;
      e = '0;
      case (m)
         2'd0: begin wide = {1'b0, d} << a; e.d = wide[W-1:0]; e.c = wide[W]; end
         2'd1: begin wide = {d, 1'b0} >> a; e.d = wide[W:1];   e.c = wide[0]; end
         2'd2: begin wide = $unsigned($signed({d, 1'b0}) >>> a); e.d = wide[W:1]; e.c = wide[0]; end
         default: begin
            dbl = {d, d} >> a;
            e.d = dbl[W-1:0];
            e.c = (a != 0) ? e.d[W-1] : 1'b0;
         end
      endcase
      e.z = (e.d == '0);
      return e;
   endfunction

   function automatic exp_t mk(input logic [W-1:0] d, input logic c, input logic z);
      exp_t e;
      e.d = d; e.c = c; e.z = z;
      return e;
   endfunction

   task automatic send(input logic [W-1:0] d, input logic [AW-1:0] a, input logic [1:0] m, input exp_t e);
      int n;
      bit done;
      in_valid = 1'b1; in_data = d; in_amount = a; in_mode = m;
      n = 0; done = 1'b0;
      while (!done && n < 200) begin
         @(negedge clk);
         if (in_ready && !reset) begin
            sb.push_back(e);
            done = 1'b1;
         end
         @(posedge clk); #1;
         n++;
      end
      if (!done) check("send_timeout", 64'd0, 64'd1);
   endtask

   task automatic send_rnd();
      logic [W-1:0]  d;
      logic [AW-1:0] a;
      logic [1:0]    m;
      d = W'($urandom);
      a = AW'($urandom_range(0, W - 1));
      m = 2'($urandom_range(0, 3));
      send(d, a, m, model(d, a, m));
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   // Monitor: handshakes are judged at the falling edge, where every input is stable.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            check("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  check("unexpected_output", 64'd1, 64'd0);
               end else begin
                  e = sb.pop_front();
                  check("out_data", 64'(out_data), 64'(e.d));
                  check("out_carry", 64'(out_carry), 64'(e.c));
                  check("out_zero", 64'(out_zero), 64'(e.z));
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      reset = 1'b1; in_valid = 1'b0; in_data = '0; in_amount = '0; in_mode = 2'b00;
      out_ready = 1'b1; rnd_done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_out_carry", 64'(out_carry), 64'd0);
      check("rst_out_zero", 64'(out_zero), 64'd0);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;

      // SRA on an empty pipe, then measure latency from the accepting edge
      send(16'h8000, 4'd3, 2'b10, mk(16'hF000, 1'b0, 1'b0));
      idle();
      cnt = 1;
      while (!out_valid && cnt < 20) begin
         @(posedge clk); #1;
         cnt++;
      end
      check("latency", 64'(cnt), 64'(P));
      wait_drain();

      send(16'h00F0, 4'd5,  2'b01, mk(16'h0007, 1'b1, 1'b0));
      send(16'h0001, 4'd15, 2'b00, mk(16'h8000, 1'b0, 1'b0));
      send(16'h8001, 4'd1,  2'b00, mk(16'h0002, 1'b1, 1'b0));
      send(16'h0001, 4'd1,  2'b11, mk(16'h8000, 1'b1, 1'b0));
      send(16'h1234, 4'd0,  2'b11, mk(16'h1234, 1'b0, 1'b0));
      send(16'h0000, 4'd4,  2'b00, mk(16'h0000, 1'b0, 1'b1));
      idle();
      wait_drain();

      // Six back-to-back beats with the consumer stalled for three cycles
      fork
         begin
            repeat (6) send_rnd();
            idle();
         end
         begin
            repeat (2) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (3) begin
               @(negedge clk);
               if (out_valid) check("stall_in_ready", 64'(in_ready), 64'd0);
            end
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      wait_drain();

      // Reset with two beats in flight
      send_rnd();
      send_rnd();
      idle();
      #1 reset = 1'b1;
      #1;
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_out_data", 64'(out_data), 64'd0);
      sb.delete();
      @(posedge clk);
      #2 reset = 1'b0;
      @(posedge clk); #1;
      send(16'hFFFF, 4'd8, 2'b01, mk(16'h00FF, 1'b1, 1'b0));
      idle();
      wait_drain();

      // Randomized traffic with random gaps and random backpressure
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               send_rnd();
               if ($urandom_range(0, 3) == 0) begin
                  idle();
                  repeat ($urandom_range(1, 3)) @(posedge clk);
                  #1;
               end
            end
            idle();
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join
      wait_drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
